// File: rtl/sh7604_rstc_pkg.sv
// sh7604_rstc_pkg
//   Shared types and constants for the SH7604 reset/standby controller.
//   RSTC_STATE_t : the five controller states.
//   RSTK_*       : reset-cause codes presented on RST_KIND for vector fetch.
package sh7604_rstc_pkg;

    typedef enum logic [2:0] {
        ST_HOLD   = 3'd0,
        ST_RUN    = 3'd1,
        ST_SLP    = 3'd2,
        ST_STBY   = 3'd3,
        ST_SETTLE = 3'd4
    } RSTC_STATE_t;

    localparam logic [1:0] RSTK_EXT = 2'b01;  // external RES_N power-on
    localparam logic [1:0] RSTK_WDT = 2'b10;  // watchdog power-on
    localparam logic [1:0] RSTK_MAN = 2'b11;  // watchdog manual

endpackage

// File: rtl/sh7604_rstc_if.sv
// sh7604_rstc_if
//   Bundles the reset sources, wake-up inputs, prescaler ticks and the
//   reset/mode outputs of the reset controller.
//   master : the surrounding system (pins, WDT, INTC, CPU) - drives the
//            request inputs and observes the reset/mode outputs.
//   slave  : the reset controller itself.
// Signalling: there is no valid/ready pairing here. Every input is a level
// or a single-tick pulse that is sampled only on cycles where EN && CE_R is
// high; every output is a register that changes only on those cycles.
interface sh7604_rstc_if;
    logic       RES_N;
    logic       NMI_N;
    logic       IRQ_PEND;
    logic       PRES;
    logic       MRES;
    logic       SLEEP_REQ;
    logic       SBY_BIT;
    logic       CLK512_CE;
    logic       CLK4096_CE;
    logic       CPU_RES_N;
    logic       MOD_RES_N;
    logic       SBY;
    logic       SLEEP;
    logic       WAKE;
    logic [1:0] RST_KIND;

    modport master (
        output RES_N, NMI_N, IRQ_PEND, PRES, MRES, SLEEP_REQ, SBY_BIT,
               CLK512_CE, CLK4096_CE,
        input  CPU_RES_N, MOD_RES_N, SBY, SLEEP, WAKE, RST_KIND
    );

    modport slave (
        input  RES_N, NMI_N, IRQ_PEND, PRES, MRES, SLEEP_REQ, SBY_BIT,
               CLK512_CE, CLK4096_CE,
        output CPU_RES_N, MOD_RES_N, SBY, SLEEP, WAKE, RST_KIND
    );
endinterface

// File: rtl/sh7604_rstc.sv
// sh7604_rstc
//   Reset and standby controller sitting downstream of the watchdog.
//   Stretches reset requests (RES_N pin, WDT PRES/MRES) into the internal
//   CPU/module resets, sequences SLEEP and software standby, and latches
//   the reset cause.
// Ports:
//   CLK, RST   : system clock, synchronous active-high reset
//   CE_R, EN   : all state updates happen only when both are high
//   bus        : sh7604_rstc_if.slave (sources, ticks, reset/mode outputs)
//   STATE_DBG  : current FSM state (debug observation)
//   CNT_DBG    : current hold/settle counter (debug observation)
module sh7604_rstc
    import sh7604_rstc_pkg::*;
#(
    parameter logic [7:0] RST_HOLD   = 8'd16,
    parameter logic [7:0] SETTLE_CNT = 8'd32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CE_R,
    input  logic              EN,
    sh7604_rstc_if.slave      bus,
    output RSTC_STATE_t       STATE_DBG,
    output logic [7:0]        CNT_DBG
);

    RSTC_STATE_t state_q, state_nx;
    logic [7:0]  cnt_q, cnt_nx;
    logic        nmi_old_q;
    logic [1:0]  kind_q, kind_nx;

    logic cpu_res_n_q, mod_res_n_q, sby_q, sleep_q, wake_q;
    logic cpu_res_n_nx, mod_res_n_nx, sby_nx, sleep_nx, wake_nx;

    logic tick;
    logic nmi_fall;
    logic wdt_ok;

    assign tick     = EN && CE_R;
    assign nmi_fall = nmi_old_q && !bus.NMI_N;
    // The watchdog is held in reset/standby outside RUN and SLP, so its
    // requests are only honoured there.
    assign wdt_ok   = (state_q == ST_RUN) || (state_q == ST_SLP);

    // State register: FSM state, counter, NMI history and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_HOLD;
            cnt_q       <= RST_HOLD;
            nmi_old_q   <= 1'b1;
            kind_q      <= RSTK_EXT;
            cpu_res_n_q <= 1'b0;
            mod_res_n_q <= 1'b0;
            sby_q       <= 1'b0;
            sleep_q     <= 1'b0;
            wake_q      <= 1'b0;
        end else if (tick) begin
            state_q     <= state_nx;
            cnt_q       <= cnt_nx;
            nmi_old_q   <= bus.NMI_N;
            kind_q      <= kind_nx;
            cpu_res_n_q <= cpu_res_n_nx;
            mod_res_n_q <= mod_res_n_nx;
            sby_q       <= sby_nx;
            sleep_q     <= sleep_nx;
            wake_q      <= wake_nx;
        end
    end

    // Next-state logic. Reset sources preempt every state transition, so a
    // SLEEP_REQ coinciding with PRES/MRES is simply lost.
    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        kind_nx  = kind_q;
        if (!bus.RES_N) begin
            state_nx = ST_HOLD;
            cnt_nx   = RST_HOLD;
            kind_nx  = RSTK_EXT;
        end else if (wdt_ok && bus.PRES) begin
            state_nx = ST_HOLD;
            cnt_nx   = RST_HOLD;
            kind_nx  = RSTK_WDT;
        end else if (wdt_ok && bus.MRES) begin
            state_nx = ST_HOLD;
            cnt_nx   = RST_HOLD;
            kind_nx  = RSTK_MAN;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == 8'd0)
                        state_nx = ST_RUN;
                    else if (bus.CLK512_CE)
                        cnt_nx = cnt_q - 8'd1;
                end
                ST_RUN: begin
                    if (bus.SLEEP_REQ)
                        state_nx = bus.SBY_BIT ? ST_STBY : ST_SLP;
                end
                ST_SLP: begin
                    if (bus.IRQ_PEND || nmi_fall)
                        state_nx = ST_RUN;
                end
                ST_STBY: begin
                    if (nmi_fall) begin
                        state_nx = ST_SETTLE;
                        cnt_nx   = SETTLE_CNT;
                    end
                end
                ST_SETTLE: begin
                    // Further NMI edges are ignored here: no reload.
                    if (cnt_q == 8'd0)
                        state_nx = ST_RUN;
                    else if (bus.CLK4096_CE)
                        cnt_nx = cnt_q - 8'd1;
                end
                default: begin
                    state_nx = ST_HOLD;
                    cnt_nx   = RST_HOLD;
                end
            endcase
        end
    end

    // Output logic: next values of the registered outputs, derived from the
    // transition being taken so they appear together with the new state.
    always_comb begin
        cpu_res_n_nx = (state_nx != ST_HOLD);
        // A manual reset leaves the on-chip modules running.
        mod_res_n_nx = !((state_nx == ST_HOLD) && (kind_nx != RSTK_MAN));
        sby_nx       = (state_nx == ST_STBY) || (state_nx == ST_SETTLE);
        sleep_nx     = (state_nx == ST_SLP);
        wake_nx      = (state_nx == ST_RUN) &&
                       ((state_q == ST_SLP) || (state_q == ST_SETTLE));
    end

    assign bus.CPU_RES_N = cpu_res_n_q;
    assign bus.MOD_RES_N = mod_res_n_q;
    assign bus.SBY       = sby_q;
    assign bus.SLEEP     = sleep_q;
    assign bus.WAKE      = wake_q;
    assign bus.RST_KIND  = kind_q;
    assign STATE_DBG     = state_q;
    assign CNT_DBG       = cnt_q;

endmodule
